data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//  Parametrised word-addressed data memory for the MIPS datapath, with a
//  valid/ready request channel, a programmable wait-state counter, byte-lane
//  writes and out-of-range error reporting. One request is in flight at a time.
//  Sits between the load/store stage and its backing RAM; replaces the single-
//  cycle, always-ready data memory.
// PARAMETERS
//  DATA_W      32   data word width in bits; must be a multiple of 8
//  ADDR_W      32   request address width; word address, no byte offset
//  DEPTH       512  number of words stored
//  WAIT_CYCLES 2    wait states between accept and access; 0..255 allowed
// PORTS
//  clk        in   1         clock; all state updates on posedge
//  rst        in   1         synchronous, active-high reset
//  req_valid  in   1         request present
//  req_ready  out  1         controller can accept a request (IDLE only)
//  req_write  in   1         1 = write, 0 = read
//  req_addr   in   ADDR_W    word address
//  req_wdata  in   DATA_W    write data
//  req_be     in   DATA_W/8  byte enables; bit i gates bits [8i+7:8i]
//  rsp_valid  out  1         one-cycle pulse: response valid
//  rsp_rdata  out  DATA_W    read data; 0 for writes and for errors
//  rsp_err    out  1         address >= DEPTH; qualified by rsp_valid
// BEHAVIOUR
//  - Reset (rst=1 at a posedge): state=IDLE, wait counter=0, req_ready=0
//    while rst is held, rsp_valid=0, rsp_rdata=0, rsp_err=0. Memory contents
//    are not cleared. req_ready=1 from the first cycle after rst deasserts.
//  - FSM IDLE->WAIT->ACCESS->RESP->IDLE.
//    IDLE: req_ready=1. On req_valid, latch write, addr, wdata and be, and load
//      the counter with WAIT_CYCLES. Go to WAIT, or to ACCESS if WAIT_CYCLES=0.
//    WAIT: decrement the counter; go to ACCESS on the edge where it reaches 0.
//      Request inputs are ignored.
//    ACCESS: if addr < DEPTH, a write updates only the enabled byte lanes and a
//      read captures mem[addr] into rsp_rdata. If addr >= DEPTH: no write,
//      rsp_rdata=0, rsp_err=1. Go to RESP.
//    RESP: rsp_valid=1 for exactly this cycle; go to IDLE.
//  - Latency: accept at edge N -> rsp_valid high in cycle N+WAIT_CYCLES+2.
//    Back-to-back accept is possible in the cycle after RESP.
//  - A write with req_be=0 completes normally with rsp_valid and no change.
//  - Read of a location written by the previous request returns the new data.
//  - rsp_rdata and rsp_err hold their values until the next ACCESS or reset.
//  - Reset mid-operation: the request is dropped with no response. A write
//    already past ACCESS stays committed; a write still in WAIT is never
//    committed.
//  - Address compare uses the full ADDR_W bits; upper bits are not truncated.
// CONFIGURATION
//  DMEM_PRELOAD_EN defined: an initial block zeroes all words, then loads
//    words 0..17 with 1,2,3,1,2,3,... These are two 3x3 test matrices:
//    A at 0..8, B at 9..17.
//  Not defined: an initial block zeroes all DEPTH words; no preload.
//  The macro has no effect on ports, the FSM or timing.
// TESTING
//  1. Reset held 3 cycles, then released -> req_ready=0 during reset and 1
//     after; rsp_valid=0, rsp_rdata=0, rsp_err=0.
//  2. WAIT_CYCLES=2: write addr 5, data 0xDEADBEEF, be=4'hF, then read addr 5
//     -> each rsp_valid 4 cycles after accept; read returns 0xDEADBEEF.
//  3. Write addr 7, 0x11223344, be=4'hF, then write addr 7, 0xAABBCCDD,
//     be=4'b0101 -> read addr 7 returns 0x11BB33DD.
//  4. Read addr 512 (DEPTH=512) -> rsp_err=1, rsp_rdata=0. Write addr 600 ->
//     rsp_err=1 and no word changes (addr 600-512=88 still reads 0).
//  5. Write addr 3, 0x55, then assert rst in the WAIT phase -> no rsp_valid;
//     after reset, read addr 3 returns the previous value (0).
//  6. WAIT_CYCLES=0 with DMEM_PRELOAD_EN: read addr 0,4,17 -> 1,2,3; each
//     response 2 cycles after accept.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Word-addressed data memory with valid/ready request channel, wait states, byte-lane writes
// and out-of-range error. Define DMEM_PRELOAD_EN to preload two 3x3 matrices at words 0..17.
module data_memory_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                mem_we;
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   mem [DEPTH];

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
`ifdef DMEM_PRELOAD_EN
    for (int i = 0; i < 18 && i < int'(DEPTH); i++) mem[i] = DATA_W'((i % 3) + 1);
`endif
  end

  // Full-width compare so aliased upper address bits still report an error.
  assign in_range  = addr_q < ADDR_W'(DEPTH);
  assign idx       = addr_q[IDX_W-1:0];
  assign req_ready = (state_q == StIdle) && !rst;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = 8'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? StAccess : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) state_d = StAccess;
      end
      StAccess: begin
        if (in_range) begin
          err_d   = 1'b0;
          mem_we  = write_q;
          rdata_d = write_q ? '0 : mem[idx];
        end else begin
          err_d   = 1'b1;
          rdata_d = '0;
        end
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // A reset landing on the ACCESS edge drops the write along with the request.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_data_memory_ctrl;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } op_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid = 1'b0, z_req_write = 1'b0;
  logic [31:0] z_req_addr = '0, z_req_wdata = '0;
  logic [3:0]  z_req_be = '0;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  data_memory_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(512), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_memory_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(512), .WAIT_CYCLES(0)) u_dut_zw (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_write(z_req_write), .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  logic        cur_sel = 1'b0;
  logic        m_ready, m_valid, m_err;
  logic [31:0] m_rdata;
  assign m_ready = cur_sel ? z_req_ready : req_ready;
  assign m_valid = cur_sel ? z_rsp_valid : rsp_valid;
  assign m_err   = cur_sel ? z_rsp_err   : rsp_err;
  assign m_rdata = cur_sel ? z_rsp_rdata : rsp_rdata;

  int    n_checks = 0;
  int    n_errors = 0;
  exp_t  exp_q[$];
  logic [31:0] model [512];

  function automatic exp_t model_apply(input op_t op);
    exp_t e;
    e.data = '0;
    e.err  = 1'b0;
    if (op.addr >= 32'd512) begin
      e.err = 1'b1;
    end else if (op.wr) begin
      for (int b = 0; b < 4; b++)
        if (op.be[b]) model[op.addr[8:0]][8*b +: 8] = op.wdata[8*b +: 8];
    end else begin
      e.data = model[op.addr[8:0]];
    end
    return e;
  endfunction

  task automatic drive(input logic sel, input logic v, input op_t op);
    if (sel) begin
      z_req_valid = v; z_req_write = op.wr; z_req_addr = op.addr;
      z_req_wdata = op.wdata; z_req_be = op.be;
    end else begin
      req_valid = v; req_write = op.wr; req_addr = op.addr;
      req_wdata = op.wdata; req_be = op.be;
    end
  endtask

  // Issue one request; returns response fields, negedges from accept to rsp_valid, ready stalls.
  task automatic send(input logic sel, input op_t op, output logic [31:0] rdata,
                      output logic err, output int lat, output int waited, output bit ok);
    ok = 1'b0; lat = 0; waited = 0; rdata = '0; err = 1'b0;
    cur_sel = sel;
    @(negedge clk);
    drive(sel, 1'b1, op);
    while (!m_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!m_ready) begin
      drive(sel, 1'b0, op);
      return;
    end
    @(posedge clk);
    #1 drive(sel, 1'b0, op);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    rdata = m_rdata;
    err   = m_err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b0 || z_req_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_ready cyc%0d: got %b/%b want 0", i, req_ready, z_req_ready);
      end
      n_checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== 34'd0) begin
        n_errors++;
        $display("FAIL reset_rsp cyc%0d: got valid=%b err=%b rdata=%h want 0", i, rsp_valid,
                 rsp_err, rsp_rdata);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || z_req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_ready: got %b/%b want 1", req_ready, z_req_ready);
    end
  endtask

  task automatic run_table(input string name, input logic sel, input op_t ops[],
                           input int exp_lat);
    logic [31:0] rd; logic er; int lat, waited; bit ok; exp_t e;
    foreach (ops[i]) begin
      exp_q.push_back(model_apply(ops[i]));
      send(sel, ops[i], rd, er, lat, waited, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL %s op%0d timeout: got no rsp_valid want rsp_valid", name, i);
      end else begin
        n_checks++;
        if (rd !== e.data) begin
          n_errors++;
          $display("FAIL %s op%0d rdata: got %h want %h", name, i, rd, e.data);
        end
        n_checks++;
        if (er !== e.err) begin
          n_errors++;
          $display("FAIL %s op%0d err: got %b want %b", name, i, er, e.err);
        end
        n_checks++;
        if (lat !== exp_lat) begin
          n_errors++;
          $display("FAIL %s op%0d latency: got %0d want %0d", name, i, lat, exp_lat);
        end
      end
    end
  endtask

  task automatic test_read_write();
    op_t ops[] = '{'{1'b1, 32'd5, 32'hDEADBEEF, 4'hF}, '{1'b0, 32'd5, 32'h0, 4'h0}};
    run_table("rw", 1'b0, ops, 4);
  endtask

  task automatic test_byte_lanes();
    op_t ops[] = '{'{1'b1, 32'd7, 32'h11223344, 4'hF}, '{1'b1, 32'd7, 32'hAABBCCDD, 4'b0101},
                   '{1'b1, 32'd7, 32'hFFFFFFFF, 4'b0000}, '{1'b0, 32'd7, 32'h0, 4'h0}};
    run_table("byte_lanes", 1'b0, ops, 4);
    n_checks++;
    if (model[7] !== 32'h11BB33DD) begin
      n_errors++;
      $display("FAIL byte_lanes_ref: got %h want 11bb33dd", model[7]);
    end
  endtask

  task automatic test_out_of_range();
    op_t ops[] = '{'{1'b0, 32'd512, 32'h0, 4'h0}, '{1'b1, 32'd600, 32'hCAFEF00D, 4'hF},
                   '{1'b0, 32'd88, 32'h0, 4'h0}, '{1'b0, 32'h0000_0204, 32'h0, 4'h0},
                   '{1'b0, 32'h8000_0005, 32'h0, 4'h0}};
    run_table("out_of_range", 1'b0, ops, 4);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat, waited; bit ok;
    op_t w = '{1'b1, 32'd9, 32'h0BADCAFE, 4'hF};
    op_t r = '{1'b0, 32'd9, 32'h0, 4'h0};
    void'(model_apply(w));
    send(1'b0, w, rd, er, lat, waited, ok);
    send(1'b0, r, rd, er, lat, waited, ok);
    n_checks++;
    if (!ok || waited !== 0) begin
      n_errors++;
      $display("FAIL back_to_back accept: got ok=%b stalls=%0d want ok=1 stalls=0", ok, waited);
    end
    n_checks++;
    if (rd !== model[9]) begin
      n_errors++;
      $display("FAIL back_to_back rdata: got %h want %h", rd, model[9]);
    end
  endtask

  task automatic test_reset_mid_op();
    op_t w = '{1'b1, 32'd3, 32'h00000055, 4'hF};
    op_t r[] = '{'{1'b0, 32'd3, 32'h0, 4'h0}};
    cur_sel = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, w);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, w);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_mid_op cyc%0d rsp_valid: got %b want 0", i, rsp_valid);
      end
    end
    rst = 1'b0;
    run_table("reset_mid_op_read", 1'b0, r, 4);
  endtask

  task automatic test_zero_wait();
    op_t ops[] = '{'{1'b0, 32'd0, 32'h0, 4'h0}, '{1'b0, 32'd4, 32'h0, 4'h0},
                   '{1'b0, 32'd17, 32'h0, 4'h0}, '{1'b0, 32'd512, 32'h0, 4'h0}};
    run_table("zero_wait", 1'b1, ops, 2);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) model[i] = '0;
`ifdef DMEM_PRELOAD_EN
    for (int i = 0; i < 18; i++) model[i] = 32'((i % 3) + 1);
`endif
    test_reset();
    // The zero-wait instance only ever sees reads, so its memory tracks the initial image.
    test_zero_wait();
    test_read_write();
    test_byte_lanes();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
